integrate_dump_clip: RTL and testbench

Integrate-and-dump decimator that consumes the strobed, clipped sum stream produced by the two-input add/clip register stage. It accumulates 2^log2_rate consecutive strobed samples, then emits their rounded mean as one strobed output word. It is the first rate-reduction stage after the adder and feeds the downstream filter chain at the reduced rate.

---
 rtl/integrate_dump_clip_pkg.sv | 35 +++
 rtl/integrate_dump_clip_round_shift_clip.sv | 37 +++
 rtl/integrate_dump_clip.sv | 105 ++++++++++
 tb/tb_integrate_dump_clip.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/integrate_dump_clip_pkg.sv
// Shared helpers for the adder/clip and integrate-and-dump stages:
// width math, saturation limits and a generic two's-complement clip.
package integrate_dump_clip_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 16;
  localparam int unsigned DEFAULT_MAX_LOG2 = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam logic signed [63:0] SAT_MAX = sat_max(DEFAULT_WIDTH);
  localparam logic signed [63:0] SAT_MIN = sat_min(DEFAULT_WIDTH);

  function automatic logic signed [63:0] clip_to_width(input logic signed [63:0] v,
                                                       input int unsigned w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < sat_min(w)) return sat_min(w);
    return v;
  endfunction

endpackage

// File: rtl/integrate_dump_clip_round_shift_clip.sv
// Combinational output stage: round-half-up, arithmetic shift by k, then
// saturate the frame sum down to a WIDTH-bit mean.
module round_shift_clip
  import integrate_dump_clip_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned MAX_LOG2 = DEFAULT_MAX_LOG2
) (
  input  logic [WIDTH+MAX_LOG2-1:0]      dump_i,
  input  logic [clog2(MAX_LOG2+1)-1:0]   k_i,
  output logic [WIDTH-1:0]               out_o
);

  localparam int unsigned AW = WIDTH + MAX_LOG2;
  // One guard bit so the rounding add can never wrap.
  localparam int unsigned SW = AW + 1;

  logic signed [SW-1:0] dump_ext;
  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;
  logic signed [63:0]   clipped;
  logic                 unused_clip_hi;

  always_comb begin
    dump_ext = {dump_i[AW-1], dump_i};
    rnd      = '0;
    if (k_i != '0) rnd = SW'(1) << (k_i - 1'b1);
    sum      = dump_ext + rnd;
    shifted  = sum >>> k_i;
    clipped  = clip_to_width(64'(shifted), WIDTH);
    out_o    = clipped[WIDTH-1:0];
  end

  assign unused_clip_hi = ^clipped[63:WIDTH];

endmodule

// File: rtl/integrate_dump_clip.sv
// Integrate-and-dump decimator: sums 2^k strobed samples, then emits their
// rounded, clipped mean as a single strobed word two edges later.
module integrate_dump_clip
  import integrate_dump_clip_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned MAX_LOG2 = DEFAULT_MAX_LOG2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [clog2(MAX_LOG2+1)-1:0] log2_rate,
  input  logic [WIDTH-1:0]             in,
  input  logic                         strobe_in,
  output logic [WIDTH-1:0]             out,
  output logic                         strobe_out
);

  localparam int unsigned AW = WIDTH + MAX_LOG2;
  localparam int unsigned KW = clog2(MAX_LOG2 + 1);

  logic [AW-1:0]       acc_q, acc_d;
  logic [AW-1:0]       dump_q, dump_d;
  logic [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic [KW-1:0]       k_lat_q, k_lat_d;
  logic [KW-1:0]       dump_k_q, dump_k_d;
  logic                dump_vld_q, dump_vld_d;
  logic                strobe_out_q, strobe_out_d;
  logic [WIDTH-1:0]    out_q, out_d;

  logic [KW-1:0]       k_new;
  logic [KW-1:0]       k_eff;
  logic                frame_last;
  logic [AW-1:0]       in_ext;
  logic [AW-1:0]       acc_sum;
  logic [WIDTH-1:0]    rsc_out;

  round_shift_clip #(
    .WIDTH    (WIDTH),
    .MAX_LOG2 (MAX_LOG2)
  ) u_round_shift_clip (
    .dump_i (dump_q),
    .k_i    (dump_k_q),
    .out_o  (rsc_out)
  );

  always_comb begin
    k_new      = (log2_rate > KW'(MAX_LOG2)) ? KW'(MAX_LOG2) : log2_rate;
    // The first sample of a frame already sees the newly latched rate.
    k_eff      = (cnt_q == '0) ? k_new : k_lat_q;
    frame_last = (32'(cnt_q) == ((32'd1 << k_eff) - 32'd1));
    in_ext     = {{MAX_LOG2{in[WIDTH-1]}}, in};
    acc_sum    = acc_q + in_ext;

    acc_d        = acc_q;
    cnt_d        = cnt_q;
    k_lat_d      = k_lat_q;
    dump_d       = dump_q;
    dump_k_d     = dump_k_q;
    dump_vld_d   = 1'b0;
    out_d        = out_q;
    strobe_out_d = dump_vld_q;

    if (strobe_in) begin
      if (cnt_q == '0) k_lat_d = k_new;
      if (frame_last) begin
        dump_d     = acc_sum;
        dump_k_d   = k_eff;
        dump_vld_d = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (dump_vld_q) out_d = rsc_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      k_lat_q      <= '0;
      dump_q       <= '0;
      dump_k_q     <= '0;
      dump_vld_q   <= 1'b0;
      strobe_out_q <= 1'b0;
      out_q        <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      k_lat_q      <= k_lat_d;
      dump_q       <= dump_d;
      dump_k_q     <= dump_k_d;
      dump_vld_q   <= dump_vld_d;
      strobe_out_q <= strobe_out_d;
      out_q        <= out_d;
    end
  end

  assign out        = out_q;
  assign strobe_out = strobe_out_q;

endmodule

// File: tb/tb_integrate_dump_clip.sv
// Bench for integrate_dump_clip: frame-level reference model checked every
// cycle, plus directed literal expectations and randomized gapped traffic.
module tb_integrate_dump_clip;

  localparam int WIDTH    = 16;
  localparam int MAX_LOG2 = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       log2_rate;
  logic [WIDTH-1:0] in;
  logic             strobe_in;
  logic [WIDTH-1:0] out;
  logic             strobe_out;

  always #5 clk = ~clk;

  integrate_dump_clip #(
    .WIDTH    (WIDTH),
    .MAX_LOG2 (MAX_LOG2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .log2_rate  (log2_rate),
    .in         (in),
    .strobe_in  (strobe_in),
    .out        (out),
    .strobe_out (strobe_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: mean of the frame's samples, rounded half-up, saturated.
  function automatic longint mean_of(input longint s, input int k);
    longint r;
    longint v;
    r = (k == 0) ? 0 : (longint'(1) << (k - 1));
    v = (s + r) >>> k;
    if (v > (longint'(1) << (WIDTH - 1)) - 1) v = (longint'(1) << (WIDTH - 1)) - 1;
    if (v < -(longint'(1) << (WIDTH - 1))) v = -(longint'(1) << (WIDTH - 1));
    return v;
  endfunction

  longint m_sum;
  int     m_n = 0;
  int     m_k = 0;
  longint m_out = 0;
  longint val_q[$];
  longint due_q[$];
  longint edge_cnt = 0;
  bit     started = 0;
  bit     exp_s;

  // Model: collects each frame, schedules its mean for the edge after the dump.
  always begin
    @(posedge clk);
    edge_cnt++;
    started = 1;
    if (rst) begin
      m_n   = 0;
      m_sum = 0;
      m_k   = 0;
      m_out = 0;
      val_q.delete();
      due_q.delete();
    end else if (strobe_in) begin
      if (m_n == 0) begin
        m_k   = (int'(log2_rate) > MAX_LOG2) ? MAX_LOG2 : int'(log2_rate);
        m_sum = 0;
      end
      m_sum += longint'($signed(in));
      m_n++;
      if (m_n == (1 << m_k)) begin
        val_q.push_back(mean_of(m_sum, m_k));
        due_q.push_back(edge_cnt + 1);
        m_n = 0;
      end
    end
  end

  always begin
    @(negedge clk);
    if (started) begin
      exp_s = (due_q.size() > 0) && (due_q[0] == edge_cnt);
      if (exp_s) begin
        m_out = val_q.pop_front();
        void'(due_q.pop_front());
      end
      check("cycle strobe_out", longint'(strobe_out), longint'(exp_s));
      check("cycle out", longint'($signed(out)), m_out);
    end
  end

  task automatic send(input int v);
    in        = WIDTH'(v);
    strobe_in = 1'b1;
    @(posedge clk);
    #1;
    strobe_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called right after the dumping sample's edge; output lands one edge later.
  task automatic expect_pulse(input string name, input int v);
    @(posedge clk);
    @(negedge clk);
    check({name, " strobe"}, longint'(strobe_out), 1);
    check(name, longint'($signed(out)), longint'(v));
  endtask

  initial begin
    int sent;
    rst       = 1'b1;
    strobe_in = 1'b0;
    in        = '0;
    log2_rate = '0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset out", longint'($signed(out)), 0);
    check("reset strobe", longint'(strobe_out), 0);

    log2_rate = 4'd2;
    send(1); send(2); send(3); send(4);
    expect_pulse("k2 1234", 3);
    send(5); send(5); send(5); send(5);
    expect_pulse("k2 5555", 5);

    log2_rate = 4'd0;
    send(7);
    expect_pulse("k0 seven", 7);
    send(-8);
    expect_pulse("k0 minus8", -8);

    log2_rate = 4'd1;
    send(-1); send(0);
    expect_pulse("k1 round -1,0", 0);
    send(-2); send(-1);
    expect_pulse("k1 round -2,-1", -1);

    log2_rate = 4'd8;
    repeat (256) send(32767);
    expect_pulse("k8 max", 32767);
    repeat (256) send(-32768);
    expect_pulse("k8 min", -32768);

    log2_rate = 4'd2;
    send(4); send(4);
    log2_rate = 4'd3;
    send(4); send(4);
    expect_pulse("rate old frame", 4);
    send(2);
    log2_rate = 4'd2;
    repeat (7) send(2);
    expect_pulse("rate new frame", 2);

    log2_rate = 4'd2;
    send(9); send(9); send(9);
    rst = 1'b1;
    send(100);
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("mid-frame reset out", longint'($signed(out)), 0);
    send(8); send(8); send(8); send(8);
    expect_pulse("post reset", 8);

    log2_rate = 4'd15;
    repeat (256) send(100);
    expect_pulse("rate15 clamp", 100);

    // Random rates, gaps and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) log2_rate = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) idle(1);
      else send(int'($urandom));
    end

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    log2_rate = 4'd15;
    sent = 0;
    while (sent < 10000) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        send(int'($urandom));
        sent++;
      end
    end

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
